// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: tracks each fetch prediction through ID/EX, checks it against the
// resolved outcome, and drives redirect/flush, the BTB/PHT update bus and saturating statistics.
module branch_resolve_unit #(
   parameter int PC_W      = 30,
   parameter int PHT_IDX_W = 8,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 if_valid,
   input  logic [PC_W-1:0]      if_pc,
   input  logic                 if_taken_pred,
   input  logic [PC_W-1:0]      if_target_pred,
   input  logic [PHT_IDX_W-1:0] if_pht_idx,
   input  logic                 id_cond,
   input  logic                 id_uncond,
   input  logic                 ex_taken,
   input  logic [PC_W-1:0]      ex_target,
   output logic                 flush,
   output logic                 redirect_valid,
   output logic [PC_W-1:0]      redirect_pc,
   output logic                 upd_valid,
   output logic [PC_W-1:0]      upd_pc,
   output logic [PC_W-1:0]      upd_target,
   output logic                 upd_cond,
   output logic                 upd_uncond,
   output logic                 upd_taken,
   output logic                 upd_inval,
   output logic [PHT_IDX_W-1:0] upd_pht_idx,
   output logic [CNT_W-1:0]     branch_cnt,
   output logic [CNT_W-1:0]     mispred_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_REDIR = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic                 id_valid_q, id_valid_d;
   logic [PC_W-1:0]      id_pc_q, id_pc_d;
   logic                 id_taken_pred_q, id_taken_pred_d;
   logic [PC_W-1:0]      id_target_pred_q, id_target_pred_d;
   logic [PHT_IDX_W-1:0] id_pht_idx_q, id_pht_idx_d;

   logic                 ex_valid_q, ex_valid_d;
   logic [PC_W-1:0]      ex_pc_q, ex_pc_d;
   logic                 ex_taken_pred_q, ex_taken_pred_d;
   logic [PC_W-1:0]      ex_target_pred_q, ex_target_pred_d;
   logic [PHT_IDX_W-1:0] ex_pht_idx_q, ex_pht_idx_d;
   logic                 ex_cond_q, ex_cond_d;
   logic                 ex_uncond_q, ex_uncond_d;

   logic                 flush_q, flush_d;
   logic                 redirect_valid_q, redirect_valid_d;
   logic [PC_W-1:0]      redirect_pc_q, redirect_pc_d;
   logic                 upd_valid_q, upd_valid_d;
   logic [PC_W-1:0]      upd_pc_q, upd_pc_d;
   logic [PC_W-1:0]      upd_target_q, upd_target_d;
   logic                 upd_cond_q, upd_cond_d;
   logic                 upd_uncond_q, upd_uncond_d;
   logic                 upd_taken_q, upd_taken_d;
   logic                 upd_inval_q, upd_inval_d;
   logic [PHT_IDX_W-1:0] upd_pht_idx_q, upd_pht_idx_d;
   logic [CNT_W-1:0]     branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]     mispred_cnt_q, mispred_cnt_d;

   logic                 resolve;
   logic                 is_branch;
   logic                 act_taken;
   logic                 false_hit;
   logic                 mispred;
   logic [PC_W-1:0]      seq_pc;
   logic [PC_W-1:0]      act_next;

   // Redirect wipes the wrong-path slots on its exit edge even if the pipe is stalled.
   always_comb begin
      id_valid_d       = id_valid_q;
      id_pc_d          = id_pc_q;
      id_taken_pred_d  = id_taken_pred_q;
      id_target_pred_d = id_target_pred_q;
      id_pht_idx_d     = id_pht_idx_q;
      ex_valid_d       = ex_valid_q;
      ex_pc_d          = ex_pc_q;
      ex_taken_pred_d  = ex_taken_pred_q;
      ex_target_pred_d = ex_target_pred_q;
      ex_pht_idx_d     = ex_pht_idx_q;
      ex_cond_d        = ex_cond_q;
      ex_uncond_d      = ex_uncond_q;
      if (state_q == ST_REDIR) begin
         id_valid_d = 1'b0;
         ex_valid_d = 1'b0;
      end else if (!stall) begin
         id_valid_d       = if_valid;
         id_pc_d          = if_pc;
         id_taken_pred_d  = if_taken_pred;
         id_target_pred_d = if_target_pred;
         id_pht_idx_d     = if_pht_idx;
         ex_valid_d       = id_valid_q;
         ex_pc_d          = id_pc_q;
         ex_taken_pred_d  = id_taken_pred_q;
         ex_target_pred_d = id_target_pred_q;
         ex_pht_idx_d     = id_pht_idx_q;
         ex_cond_d        = id_cond;
         ex_uncond_d      = id_uncond;
      end
   end

   always_comb begin
      resolve   = ex_valid_q & ~stall & (state_q == ST_RUN);
      is_branch = ex_cond_q | ex_uncond_q;
      act_taken = ex_uncond_q | (ex_cond_q & ex_taken);
      false_hit = ex_taken_pred_q & ~is_branch;
      seq_pc    = ex_pc_q + PC_W'(1);
      act_next  = act_taken ? ex_target : seq_pc;
      mispred   = (ex_taken_pred_q != act_taken) |
                  (ex_taken_pred_q & act_taken & (ex_target_pred_q != ex_target));
   end

   // Outputs are zero unless this cycle resolves something, which makes them one-cycle pulses.
   always_comb begin
      flush_d          = 1'b0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = '0;
      upd_valid_d      = 1'b0;
      upd_pc_d         = '0;
      upd_target_d     = '0;
      upd_cond_d       = 1'b0;
      upd_uncond_d     = 1'b0;
      upd_taken_d      = 1'b0;
      upd_inval_d      = 1'b0;
      upd_pht_idx_d    = '0;
      branch_cnt_d     = branch_cnt_q;
      mispred_cnt_d    = mispred_cnt_q;
      if (resolve) begin
         if (mispred) begin
            flush_d          = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = act_next;
            if (!(&mispred_cnt_q)) begin
               mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
            end
         end
         if (is_branch || false_hit) begin
            upd_valid_d   = 1'b1;
            upd_pc_d      = ex_pc_q;
            upd_target_d  = is_branch ? ex_target : '0;
            upd_cond_d    = ex_cond_q;
            upd_uncond_d  = ex_uncond_q;
            upd_taken_d   = act_taken;
            upd_inval_d   = false_hit;
            upd_pht_idx_d = ex_pht_idx_q;
         end
         if (is_branch && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
         end
      end
   end

   // REDIR and DRAIN each last exactly one cycle; stall cannot hold them.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (resolve && mispred) state_d = ST_REDIR;
         ST_REDIR: state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_RUN;
         id_valid_q       <= 1'b0;
         id_pc_q          <= '0;
         id_taken_pred_q  <= 1'b0;
         id_target_pred_q <= '0;
         id_pht_idx_q     <= '0;
         ex_valid_q       <= 1'b0;
         ex_pc_q          <= '0;
         ex_taken_pred_q  <= 1'b0;
         ex_target_pred_q <= '0;
         ex_pht_idx_q     <= '0;
         ex_cond_q        <= 1'b0;
         ex_uncond_q      <= 1'b0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         upd_valid_q      <= 1'b0;
         upd_pc_q         <= '0;
         upd_target_q     <= '0;
         upd_cond_q       <= 1'b0;
         upd_uncond_q     <= 1'b0;
         upd_taken_q      <= 1'b0;
         upd_inval_q      <= 1'b0;
         upd_pht_idx_q    <= '0;
         branch_cnt_q     <= '0;
         mispred_cnt_q    <= '0;
      end else begin
         state_q          <= state_d;
         id_valid_q       <= id_valid_d;
         id_pc_q          <= id_pc_d;
         id_taken_pred_q  <= id_taken_pred_d;
         id_target_pred_q <= id_target_pred_d;
         id_pht_idx_q     <= id_pht_idx_d;
         ex_valid_q       <= ex_valid_d;
         ex_pc_q          <= ex_pc_d;
         ex_taken_pred_q  <= ex_taken_pred_d;
         ex_target_pred_q <= ex_target_pred_d;
         ex_pht_idx_q     <= ex_pht_idx_d;
         ex_cond_q        <= ex_cond_d;
         ex_uncond_q      <= ex_uncond_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         upd_valid_q      <= upd_valid_d;
         upd_pc_q         <= upd_pc_d;
         upd_target_q     <= upd_target_d;
         upd_cond_q       <= upd_cond_d;
         upd_uncond_q     <= upd_uncond_d;
         upd_taken_q      <= upd_taken_d;
         upd_inval_q      <= upd_inval_d;
         upd_pht_idx_q    <= upd_pht_idx_d;
         branch_cnt_q     <= branch_cnt_d;
         mispred_cnt_q    <= mispred_cnt_d;
      end
   end

   assign flush          = flush_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign upd_valid      = upd_valid_q;
   assign upd_pc         = upd_pc_q;
   assign upd_target     = upd_target_q;
   assign upd_cond       = upd_cond_q;
   assign upd_uncond     = upd_uncond_q;
   assign upd_taken      = upd_taken_q;
   assign upd_inval      = upd_inval_q;
   assign upd_pht_idx    = upd_pht_idx_q;
   assign branch_cnt     = branch_cnt_q;
   assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: stimulus pushes hand-computed expectations into a
// scoreboard queue, a negedge monitor pops one entry whenever an update or redirect appears.
module tb_branch_resolve_unit;

   localparam int PC_W  = 30;
   localparam int IDX_W = 8;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             clk = 1'b0;
   logic             rst, stall, if_valid, if_taken_pred, id_cond, id_uncond, ex_taken;
   logic [PC_W-1:0]  if_pc, if_target_pred, ex_target;
   logic [IDX_W-1:0] if_pht_idx;
   logic             flush, redirect_valid, upd_valid, upd_cond, upd_uncond, upd_taken, upd_inval;
   logic [PC_W-1:0]  redirect_pc, upd_pc, upd_target;
   logic [IDX_W-1:0] upd_pht_idx;
   logic [CNT_W-1:0] branch_cnt, mispred_cnt;

   branch_resolve_unit #(.PC_W(PC_W), .PHT_IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .if_valid(if_valid), .if_pc(if_pc), .if_taken_pred(if_taken_pred),
      .if_target_pred(if_target_pred), .if_pht_idx(if_pht_idx),
      .id_cond(id_cond), .id_uncond(id_uncond), .ex_taken(ex_taken), .ex_target(ex_target),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_cond(upd_cond), .upd_uncond(upd_uncond), .upd_taken(upd_taken),
      .upd_inval(upd_inval), .upd_pht_idx(upd_pht_idx),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PC_W-1:0]  pc;
      logic             tp;
      logic [PC_W-1:0]  tgt_pred;
      logic [IDX_W-1:0] idx;
      logic             cond, uncond, taken;
      logic [PC_W-1:0]  target;
      int               nstall;
      logic             stall_redir, rst_redir;
      logic             e_upd, e_redir;
      logic [PC_W-1:0]  e_redir_pc;
      logic             e_taken, e_inval;
   } vec_t;

   typedef struct {
      logic             redir;
      logic [PC_W-1:0]  redir_pc;
      logic             upd;
      logic [PC_W-1:0]  upd_pc, upd_target;
      logic             cond, uncond, taken, inval;
      logic [IDX_W-1:0] idx;
      logic [CNT_W-1:0] bcnt, mcnt;
   } exp_t;

   exp_t             sb[$];
   int               n_checks = 0;
   int               n_fail = 0;
   logic             mon_en = 1'b0;
   logic [CNT_W-1:0] bcnt_model = '0;
   logic [CNT_W-1:0] mcnt_model = '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkIdle(input string name);
      checkOutput({name, "_upd"}, 32'(upd_valid), 32'd0);
      checkOutput({name, "_redir"}, 32'(redirect_valid), 32'd0);
      checkOutput({name, "_flush"}, 32'(flush), 32'd0);
   endtask

   // Monitor: every cycle that shows an update or redirect must match the oldest expectation.
   always @(negedge clk) begin
      if (mon_en && (upd_valid || redirect_valid || flush)) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_output", {29'd0, flush, redirect_valid, upd_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("redirect_valid", 32'(redirect_valid), 32'(e.redir));
            checkOutput("flush", 32'(flush), 32'(e.redir));
            checkOutput("redirect_pc", 32'(redirect_pc), 32'(e.redir_pc));
            checkOutput("upd_valid", 32'(upd_valid), 32'(e.upd));
            checkOutput("upd_pc", 32'(upd_pc), 32'(e.upd_pc));
            checkOutput("upd_target", 32'(upd_target), 32'(e.upd_target));
            checkOutput("upd_cond", 32'(upd_cond), 32'(e.cond));
            checkOutput("upd_uncond", 32'(upd_uncond), 32'(e.uncond));
            checkOutput("upd_taken", 32'(upd_taken), 32'(e.taken));
            checkOutput("upd_inval", 32'(upd_inval), 32'(e.inval));
            checkOutput("upd_pht_idx", 32'(upd_pht_idx), 32'(e.idx));
            checkOutput("branch_cnt", 32'(branch_cnt), 32'(e.bcnt));
            checkOutput("mispred_cnt", 32'(mispred_cnt), 32'(e.mcnt));
         end
      end
   end

   function automatic vec_t mkVec(
      input logic [PC_W-1:0] pc, input logic tp, input logic [PC_W-1:0] tgt_pred,
      input logic [IDX_W-1:0] idx, input logic cond, input logic uncond, input logic taken,
      input logic [PC_W-1:0] target, input int nstall, input logic stall_redir,
      input logic rst_redir, input logic e_upd, input logic e_redir,
      input logic [PC_W-1:0] e_redir_pc, input logic e_taken, input logic e_inval);
      vec_t v;
      v.pc = pc; v.tp = tp; v.tgt_pred = tgt_pred; v.idx = idx;
      v.cond = cond; v.uncond = uncond; v.taken = taken; v.target = target;
      v.nstall = nstall; v.stall_redir = stall_redir; v.rst_redir = rst_redir;
      v.e_upd = e_upd; v.e_redir = e_redir; v.e_redir_pc = e_redir_pc;
      v.e_taken = e_taken; v.e_inval = e_inval;
      return v;
   endfunction

   // One instruction walks IF -> ID -> EX; optional stall in EX, stall or reset during REDIR.
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      @(negedge clk);
      if_valid = 1'b1; if_pc = v.pc; if_taken_pred = v.tp;
      if_target_pred = v.tgt_pred; if_pht_idx = v.idx;
      @(negedge clk);
      if_valid = 1'b0; if_taken_pred = 1'b0;
      id_cond = v.cond; id_uncond = v.uncond;
      @(negedge clk);
      id_cond = 1'b0; id_uncond = 1'b0;
      ex_taken = v.taken; ex_target = v.target;
      if (v.nstall > 0) stall = 1'b1;
      for (int s = 0; s < v.nstall; s++) begin
         @(negedge clk);
         checkIdle("stall_hold");
      end
      stall = 1'b0;
      if ((v.cond || v.uncond) && bcnt_model != CNT_MAX) bcnt_model = bcnt_model + 1'b1;
      if (v.e_redir && mcnt_model != CNT_MAX) mcnt_model = mcnt_model + 1'b1;
      if (v.e_upd || v.e_redir) begin
         e.redir = v.e_redir;
         e.redir_pc = v.e_redir ? v.e_redir_pc : '0;
         e.upd = v.e_upd;
         e.upd_pc = v.e_upd ? v.pc : '0;
         e.upd_target = (v.e_upd && !v.e_inval) ? v.target : '0;
         e.cond = v.e_upd & v.cond;
         e.uncond = v.e_upd & v.uncond;
         e.taken = v.e_taken;
         e.inval = v.e_inval;
         e.idx = v.e_upd ? v.idx : '0;
         e.bcnt = bcnt_model;
         e.mcnt = mcnt_model;
         sb.push_back(e);
      end
      @(negedge clk);
      ex_taken = 1'b0; ex_target = '0;
      if (v.stall_redir) stall = 1'b1;
      if (v.rst_redir) rst = 1'b1;
      @(negedge clk);
      if (v.rst_redir) begin
         checkIdle("rst_redir");
         checkOutput("rst_redir_pc", 32'(redirect_pc), 32'd0);
         checkOutput("rst_upd_pc", 32'(upd_pc), 32'd0);
         checkOutput("rst_branch_cnt", 32'(branch_cnt), 32'd0);
         checkOutput("rst_mispred_cnt", 32'(mispred_cnt), 32'd0);
         rst = 1'b0;
         bcnt_model = '0;
         mcnt_model = '0;
      end
      @(negedge clk);
      stall = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; if_valid = 1'b0; if_pc = '0; if_taken_pred = 1'b0;
      if_target_pred = '0; if_pht_idx = '0; id_cond = 1'b0; id_uncond = 1'b0;
      ex_taken = 1'b0; ex_target = '0;
      repeat (3) @(negedge clk);
      checkIdle("reset");
      checkOutput("reset_branch_cnt", 32'(branch_cnt), 32'd0);
      checkOutput("reset_mispred_cnt", 32'(mispred_cnt), 32'd0);
      checkOutput("reset_redirect_pc", 32'(redirect_pc), 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;

      // Correct taken cond branch: update only.
      applyStimulus(mkVec(30'h100, 1, 30'h200, 8'h11, 1, 0, 1, 30'h200, 0, 0, 0, 1, 0, 30'h0, 1, 0));
      // Predicted taken, actually not taken: redirect to pc+1.
      applyStimulus(mkVec(30'h100, 1, 30'h200, 8'h22, 1, 0, 0, 30'h200, 0, 0, 0, 1, 1, 30'h101, 0, 0));
      // Taken both ways but wrong target.
      applyStimulus(mkVec(30'h300, 1, 30'h400, 8'h33, 1, 0, 1, 30'h404, 0, 0, 0, 1, 1, 30'h404, 1, 0));
      // Uncond jump predicted not taken.
      applyStimulus(mkVec(30'h40, 0, 30'h0, 8'h44, 0, 1, 0, 30'h80, 0, 0, 0, 1, 1, 30'h80, 1, 0));
      // False hit at the top of the PC space: sequential PC wraps to 0.
      applyStimulus(mkVec(30'h3FFF_FFFF, 1, 30'h123, 8'h55, 0, 0, 0, 30'h55, 0, 0, 0, 1, 1, 30'h0, 0, 1));
      // Plain non-branch, not predicted: nothing happens.
      applyStimulus(mkVec(30'h500, 0, 30'h0, 8'h66, 0, 0, 1, 30'h77, 0, 0, 0, 0, 0, 30'h0, 0, 0));
      // Correctly predicted not-taken cond branch.
      applyStimulus(mkVec(30'h600, 0, 30'h0, 8'h77, 1, 0, 0, 30'h700, 0, 0, 0, 1, 0, 30'h0, 0, 0));
      // Mispredict held by a 3-cycle stall in EX.
      applyStimulus(mkVec(30'h800, 0, 30'h0, 8'h88, 1, 0, 1, 30'h900, 3, 0, 0, 1, 1, 30'h900, 1, 0));
      // Stall raised during REDIR must not stretch the redirect pulse.
      applyStimulus(mkVec(30'h900, 1, 30'hA00, 8'h99, 1, 0, 0, 30'hA00, 0, 1, 0, 1, 1, 30'h901, 0, 0));

      // Push both counters past all-ones.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(mkVec(30'(30'h1000 + i), 0, 30'h0, 8'(i), 1, 0, 1, 30'h2000,
                             0, 0, 0, 1, 1, 30'h2000, 1, 0));
      end
      checkOutput("mispred_saturated", 32'(mispred_cnt), 32'hF);
      checkOutput("branch_saturated", 32'(branch_cnt), 32'hF);

      // Reset while the redirect is showing abandons it.
      applyStimulus(mkVec(30'hB00, 1, 30'hC00, 8'hAA, 1, 0, 0, 30'hC00, 0, 0, 1, 1, 1, 30'hB01, 0, 0));
      // Normal operation after reset, counters restart from zero.
      applyStimulus(mkVec(30'hD00, 1, 30'hE00, 8'hBB, 1, 0, 1, 30'hE00, 0, 0, 0, 1, 0, 30'h0, 1, 0));

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
